// File: rtl/data_mem_bank.sv
// Word-addressed data RAM bank with a posted-write FIFO in front of a single-port array.
// Reads forward from the newest pending write and have priority over draining.
module data_mem_bank #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WB_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_read_en,
  input  logic                          mem_write_en,
  input  logic [DATA_WIDTH-1:0]         mem_write_val,
  output logic [DATA_WIDTH-1:0]         mem_read_val,
  output logic                          mem_read_valid,
  output logic                          mem_stall,
  output logic [$clog2(WB_DEPTH):0]     wb_count
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  wb_entry_t             wb_q [WB_DEPTH];
  logic [PTR_W-1:0]      head, tail, idx;
  logic [CNT_W-1:0]      count;
  logic                  rd_acc, wr_acc, pop, fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign mem_stall = (count == CNT_W'(WB_DEPTH));
  assign wb_count  = count;
  assign rd_acc    = mem_read_en  & ~mem_stall;
  assign wr_acc    = mem_write_en & ~mem_stall;
  // single array port: an accepted read blocks the drain for that edge
  assign pop       = (count != '0) & ~rd_acc;

  // walk oldest to newest so the last hit is the newest matching entry
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (CNT_W'(i) < count && wb_q[idx].addr == mem_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_q[idx].data;
      end
      idx = idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      mem_read_val   <= '0;
      mem_read_valid <= 1'b0;
    end else begin
      if (wr_acc) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      count          <= count + CNT_W'(wr_acc) - CNT_W'(pop);
      mem_read_valid <= rd_acc;
      if (rd_acc) mem_read_val <= fwd_hit ? fwd_data : mem[mem_addr];
    end
  end

  // entry payloads need no reset; occupancy is governed by count
  always_ff @(posedge clk) begin
    if (wr_acc) wb_q[tail] <= '{addr: mem_addr, data: mem_write_val};
  end

  // gated by reset so discarded buffered writes never land in the array
  always_ff @(posedge clk) begin
    if (pop && !reset) mem[wb_q[head].addr] <= wb_q[head].data;
  end
endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench for data_mem_bank: a queue/array reference model checked every cycle,
// plus literal expectations at the points of interest.
module tb_data_mem_bank;
  localparam int AW = 8, DW = 32, WBD = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] mem_addr = '0;
  logic          mem_read_en = 1'b0, mem_write_en = 1'b0;
  logic [DW-1:0] mem_write_val = '0;
  logic [DW-1:0] mem_read_val;
  logic          mem_read_valid, mem_stall;
  logic [$clog2(WBD):0] wb_count;

  int total = 0, bad = 0;
  bit armed = 0;

  data_mem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WB_DEPTH(WBD)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_val(mem_write_val),
    .mem_read_val(mem_read_val), .mem_read_valid(mem_read_valid),
    .mem_stall(mem_stall), .wb_count(wb_count));

  always #5 clk = ~clk;

  // reference model: pending writes as a queue, array as plain memory with known bits
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           q[$];
  logic [DW-1:0] arr_m [256];
  bit            arr_k [256];
  logic [DW-1:0] exp_val = '0;
  bit            exp_vld = 0, exp_known = 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      exp_val = '0; exp_vld = 0; exp_known = 1;
    end else begin
      int  n0;
      bit  full, racc, wacc, hit;
      wr_t w;
      n0   = q.size();
      full = (n0 == WBD);
      racc = mem_read_en && !full;
      wacc = mem_write_en && !full;
      if (racc) begin
        hit = 0;
        foreach (q[i]) if (q[i].a == mem_addr) begin hit = 1; exp_val = q[i].d; end
        if (hit) exp_known = 1;
        else begin exp_known = arr_k[mem_addr]; exp_val = arr_m[mem_addr]; end
      end
      exp_vld = racc;
      if (wacc) begin w.a = mem_addr; w.d = mem_write_val; q.push_back(w); end
      if (!racc && n0 > 0) begin
        w = q.pop_front();
        arr_m[w.a] = w.d; arr_k[w.a] = 1;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    total++;
    if (mem_read_valid !== exp_vld) begin
      bad++; $display("FAIL model_valid t=%0t got=%0b want=%0b", $time, mem_read_valid, exp_vld);
    end
    total++;
    if (wb_count !== q.size()) begin
      bad++; $display("FAIL model_count t=%0t got=%0d want=%0d", $time, wb_count, q.size());
    end
    total++;
    if (mem_stall !== (q.size() == WBD)) begin
      bad++; $display("FAIL model_stall t=%0t got=%0b want=%0b", $time, mem_stall, q.size() == WBD);
    end
    if (exp_known) begin
      total++;
      if (mem_read_val !== exp_val) begin
        bad++; $display("FAIL model_rdata t=%0t got=%h want=%h", $time, mem_read_val, exp_val);
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++; $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // drive one request for exactly one rising edge; returns 2 time units after that edge
  task automatic step(input bit re, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_read_en = re; mem_write_en = we; mem_addr = a; mem_write_val = d;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    armed = 1;
    chk("reset_valid", {31'b0, mem_read_valid}, 32'h0);
    chk("reset_val", mem_read_val, 32'h0);
    chk("reset_count", 32'(wb_count), 32'h0);

    // forward from buffer, then from array after drain
    step(0, 1, 8'h10, 32'hDEADBEEF);
    step(1, 0, 8'h10, '0);
    chk("fwd_valid", {31'b0, mem_read_valid}, 32'h1);
    chk("fwd_val", mem_read_val, 32'hDEADBEEF);
    idle(4);
    step(1, 0, 8'h10, '0);
    chk("array_val", mem_read_val, 32'hDEADBEEF);
    chk("array_count", 32'(wb_count), 32'h0);
    idle(1);
    chk("valid_pulse_one_cycle", {31'b0, mem_read_valid}, 32'h0);

    // fill with reads blocking drain, then held write while stalled
    for (int i = 0; i < 4; i++) step(1, 1, 8'h50 + 8'(i), 32'h100 + 32'(i));
    chk("full_count", 32'(wb_count), 32'h4);
    chk("full_stall", {31'b0, mem_stall}, 32'h1);
    step(0, 1, 8'h60, 32'h66);
    chk("held_count", 32'(wb_count), 32'h3);
    chk("held_stall", {31'b0, mem_stall}, 32'h0);
    step(0, 1, 8'h60, 32'h66);
    chk("accept_count", 32'(wb_count), 32'h3);
    idle(5);
    step(1, 0, 8'h60, '0);
    chk("held_write_landed", mem_read_val, 32'h66);
    step(1, 0, 8'h53, '0);
    chk("fill_write_landed", mem_read_val, 32'h103);

    // duplicate addresses: newest wins
    idle(2);
    step(1, 1, 8'h20, 32'h1);
    step(1, 1, 8'h20, 32'h2);
    chk("dup_first_fwd", mem_read_val, 32'h1);
    step(1, 0, 8'h20, '0);
    chk("dup_newest", mem_read_val, 32'h2);
    chk("dup_count", 32'(wb_count), 32'h2);
    idle(5);
    step(1, 0, 8'h20, '0);
    chk("dup_drained", mem_read_val, 32'h2);

    // same-edge read and write returns old value
    step(0, 1, 8'h30, 32'hAAAA);
    idle(3);
    step(1, 1, 8'h30, 32'hBBBB);
    chk("rw_old", mem_read_val, 32'hAAAA);
    step(1, 0, 8'h30, '0);
    chk("rw_new", mem_read_val, 32'hBBBB);

    // reset discards buffered write
    step(0, 1, 8'h40, 32'h5);
    idle(3);
    step(1, 1, 8'h40, 32'h9);
    chk("pre_reset_val", mem_read_val, 32'h5);
    mem_read_en = 0; mem_write_en = 0;
    reset = 1'b1;
    #1;
    chk("midreset_val", mem_read_val, 32'h0);
    chk("midreset_valid", {31'b0, mem_read_valid}, 32'h0);
    chk("midreset_count", 32'(wb_count), 32'h0);
    @(posedge clk); #2 reset = 1'b0;
    idle(3);
    step(1, 0, 8'h40, '0);
    chk("post_reset_array", mem_read_val, 32'h5);

    // address extremes
    step(0, 1, 8'hFF, 32'h12345678);
    step(0, 1, 8'h00, 32'h87654321);
    idle(4);
    step(1, 0, 8'hFF, '0);
    chk("addr_top", mem_read_val, 32'h12345678);
    step(1, 0, 8'h00, '0);
    chk("addr_zero", mem_read_val, 32'h87654321);
    idle(2);

    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
